// File: rtl/multiword_rca_seq_pkg.sv
// Shared definitions for the multi-word ripple-carry adder controller:
// word width, controller state encoding and counter sizing.
package multiword_rca_seq_pkg;

  localparam int WORD_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int cnt_width(input int num_words);
    return $clog2(num_words);
  endfunction

endpackage

// File: rtl/multiword_rca_seq_if.sv
// Operand/sum stream bundle between a word source/sink (master) and the
// multi-word adder controller (slave).
interface multiword_rca_seq_if;
  import multiword_rca_seq_pkg::*;

  // Both streams use valid/ready: a word moves on a rising edge where valid
  // and ready are both high; valid never waits on ready, and the payload is
  // held stable while valid is high and ready is low.
  logic              start;
  logic              c_in;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] sum_word;
  logic              out_last;
  logic              c_out_final;
  logic              busy;
  logic              done;

  modport master (
    output start, c_in, in_valid, a_word, b_word, out_ready,
    input  in_ready, out_valid, sum_word, out_last, c_out_final, busy, done
  );

  modport slave (
    input  start, c_in, in_valid, a_word, b_word, out_ready,
    output in_ready, out_valid, sum_word, out_last, c_out_final, busy, done
  );

endinterface

// File: rtl/multiword_rca_seq_rca.sv
// 3-bit ripple-carry adder: bitwise full adders chained from c_in to c_out.
module ripple_carry_adder
  import multiword_rca_seq_pkg::*;
(
  input  logic              c_in,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] sum,
  output logic              c_out
);

  logic [WORD_W:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < WORD_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[WORD_W];

endmodule

// File: rtl/multiword_rca_seq.sv
// Streams NUM_WORDS little-endian 3-bit word pairs through one ripple-carry
// adder, carrying between words, into a one-entry registered sum output.
module multiword_rca_seq
  import multiword_rca_seq_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  multiword_rca_seq_if.slave  bus,
  output state_t              dbg_state
);

  localparam int              CNT_W    = cnt_width(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  state_t            state, state_nxt;
  logic              carry_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] sum_q;
  logic              out_valid_q, out_last_q, c_out_final_q, done_q;

  logic [WORD_W-1:0] add_sum;
  logic              add_c;
  logic              in_ready, in_hs, out_hs, last_word, start_acc, done_nxt;

  ripple_carry_adder u_adder (
    .c_in  (carry_q),
    .a     (bus.a_word),
    .b     (bus.b_word),
    .sum   (add_sum),
    .c_out (add_c)
  );

  assign last_word = (cnt_q == LAST_IDX);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    start_acc = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          start_acc = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Accept a new pair only if the output slot is free or emptying now.
        in_ready = !out_valid_q || bus.out_ready;
        if (bus.in_valid && in_ready && last_word) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_valid_q && bus.out_ready && out_last_q) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_hs  = bus.in_valid && in_ready;
  assign out_hs = out_valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q       <= 1'b0;
      cnt_q         <= '0;
      sum_q         <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      c_out_final_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= done_nxt;
      if (start_acc) begin
        carry_q <= bus.c_in;
        cnt_q   <= '0;
      end else if (in_hs) begin
        carry_q <= add_c;
        cnt_q   <= cnt_q + 1'b1;
      end
      // A new word takes priority: simultaneous in/out handshakes reload.
      if (in_hs) begin
        sum_q       <= add_sum;
        out_valid_q <= 1'b1;
        out_last_q  <= last_word;
        if (last_word) c_out_final_q <= add_c;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.sum_word    = sum_q;
  assign bus.out_last    = out_last_q;
  assign bus.c_out_final = c_out_final_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign dbg_state       = state;

endmodule

// File: doc/multiword_rca_seq.md
# multiword_rca_seq

Sequential multi-word adder controller that sits directly upstream of `ripple_carry_adder` (3-bit, ports `c_in`, `a`, `b`, `sum`, `c_out`). It accepts a little-endian stream of 3-bit operand word pairs, drives each pair through one adder instance, and registers the adder's carry between words so that `NUM_WORDS` 3-bit words form one wide addition. Sum words leave through a one-entry registered output with a valid/ready handshake. After the last word it reports the final carry-out and a completion pulse.

## Interface
- `NUM_WORDS`, default 4: number of 3-bit words per operand, minimum 2. Operand width is 3*`NUM_WORDS`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle pulse that begins an addition. Sampled only in IDLE.
- `c_in`  in  1  initial carry, latched on an accepted `start`.
- `in_valid`  in  1  the current `a_word`/`b_word` pair is valid.
- `in_ready`  out  1  the block accepts the pair this cycle.
- `a_word`, `b_word`  in  3 each  operand words, least-significant word first.
- `out_valid`  out  1  `sum_word` is valid.
- `out_ready`  in  1  downstream accepts `sum_word`.
- `sum_word`  out  3  registered sum word.
- `out_last`  out  1  qualifies the final sum word.
- `c_out_final`  out  1  final carry. Meaningful when `out_valid && out_last`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when the last word is consumed.

## Operation
- States:
  - IDLE: `in_ready`=0. `start` latches `c_in` into the carry register, clears the word counter, and moves to RUN.
  - RUN: `in_ready` = `!out_valid || out_ready`. On each input handshake:
    - the adder computes `{c, s} = a_word + b_word + carry`;
    - `s` loads `sum_word` and `out_valid` is set;
    - `c` loads the carry register;
    - the counter increments;
    - if the counter equals `NUM_WORDS`-1, `out_last` is set, `c` is also loaded into `c_out_final`, and the state moves to DRAIN.
  - DRAIN: `in_ready`=0. When the last word handshakes out, `done` pulses for one cycle and the state returns to IDLE.
- Output register:
  - An output handshake without a new input clears `out_valid` and `out_last`.
  - A simultaneous input and output handshake reloads the register, giving 1 word/cycle throughput.
- `sum_word` and `out_last` stay stable while `out_valid && !out_ready`.
- Ignored inputs:
  - `start` outside IDLE is ignored.
  - `in_valid` in IDLE or DRAIN is ignored. The block never accepts words beyond `NUM_WORDS`.
- Arithmetic is modulo 2^(3*`NUM_WORDS`). Overflow is reported only via `c_out_final`.
- Reset values: all outputs 0, state IDLE, carry register 0, counter 0.
- Reset mid-operation discards the partial result, returns to IDLE, and emits no `done`.

## Timing
- Latency: a pair accepted at edge k gives `out_valid`=1 and `sum_word` in the cycle after edge k.
- `start` at edge k gives `busy`=1 and `in_ready` possibly 1 in the cycle after edge k. `start` and `in_valid` in the same IDLE cycle accept no word.
- With `out_ready` held high, `NUM_WORDS` words take `NUM_WORDS` cycles. `done` asserts one cycle after the last output handshake edge, then IDLE.
- Backpressure: when `out_valid && !out_ready`, `in_ready` drops combinationally in the same cycle.
- The adder path is combinational between the input and output registers: one 3-bit ripple per cycle.

## Structure
- Shared package holds:
  - `WORD_W` = 3;
  - the state enum {IDLE, RUN, DRAIN};
  - the counter width `$clog2(NUM_WORDS)`.
- One sub-module: the existing `ripple_carry_adder`, instantiated once with ports `c_in`, `a`, `b`, `sum`, `c_out`. The carry register feeds its `c_in`.

## Test plan
- Reset: hold `rst_n`=0 with random inputs. All outputs read 0 and `busy`=0. After release, `in_ready` stays 0 until `start`.
- Carry chaining, `NUM_WORDS`=2, `c_in`=0:
  - word0 a=111, b=001 gives sum 000;
  - word1 a=001, b=010 gives sum 100 with `out_last`=1;
  - `c_out_final`=0 (15+17=32); `done` pulses once.
- Overflow, `NUM_WORDS`=2, `c_in`=1: a words 111,111 and b words 000,000 give sums 000,000 with `c_out_final`=1 (63+0+1=64).
- Backpressure, `NUM_WORDS`=4: after word0 (011+010 gives 101), hold `out_ready`=0 for 3 cycles. `in_ready`=0 and `sum_word`=101 hold. When released, the remaining words stream at 1/cycle.
- Protocol abuse: `start` during RUN is ignored. A 5th `in_valid` in DRAIN is not accepted. `start` and `in_valid` in the same IDLE cycle accept no word.
- Reset mid-operation: assert `rst_n`=0 after word1 of 4. Outputs clear, no `done` appears, and a following `start` runs a fresh addition correctly.
